// File: rtl/alu_commit_queue.sv
// alu_commit_queue
// Purpose: in-order result buffer between the multi-cycle maths ALU and the
//   register-file writeback port. ALU results come in through the req/clear
//   commit handshake and go out to writeback through a valid/ready handshake.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   alu_res/rd/valid/error    ALU result bundle
//   alu_req -> alu_clear      commit handshake (clear is a 1-cycle pulse)
//   flush                     discard every queued entry
//   wb_valid/ready/data/rd/error  writeback handshake and head entry
//   count/full/empty          occupancy status
// Latency: push to wb_valid 1 cycle; capture to alu_clear 1 cycle.
// Backpressure: when full, alu_req is held off (no alu_clear) until a pop is
//   registered; a pop and a push in the same cycle leave count unchanged.
// Optional feature: define ALU_COMMIT_X0_DROP_EN to drop error-free results
//   whose destination is x0 (the ALU is still released).
module alu_commit_queue #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XLEN-1:0]          alu_res,
  input  logic [REG_ADDR_W-1:0]    alu_rd,
  input  logic                     alu_valid,
  input  logic                     alu_error,
  input  logic                     alu_req,
  output logic                     alu_clear,
  input  logic                     flush,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [XLEN-1:0]          wb_data,
  output logic [REG_ADDR_W-1:0]    wb_rd,
  output logic                     wb_error,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic                  err_q  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          clear_q, clear_d;

  logic capture;   // handshake accepted this cycle (ALU will be released)
  logic enq;       // captured entry actually written into the buffer
  logic pop;
  logic drop;

`ifdef ALU_COMMIT_X0_DROP_EN
  // Error-free writes to x0 have no architectural effect; only the release
  // of the ALU matters. Errors to x0 are kept so they still get reported.
  assign drop = (alu_rd == '0) && !alu_error;
`else
  assign drop = 1'b0;
`endif

  // Status from registered count only, so a same-cycle pop never lets a
  // push in while full and no input reaches an output combinationally.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign wb_valid = !empty;
  assign alu_clear = clear_q;

  assign wb_data  = data_q[rd_ptr_q];
  assign wb_rd    = rd_q[rd_ptr_q];
  assign wb_error = err_q[rd_ptr_q];

  always_comb begin
    // While clear_q is high the ALU still holds its previous req, so that
    // cycle must not be taken as a new result.
    capture  = alu_req && alu_valid && !full && !clear_q && !flush;
    enq      = capture && !drop;
    pop      = wb_valid && wb_ready && !flush;
    clear_d  = capture;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({enq, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      clear_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      clear_q  <= clear_d;
    end
  end

  // Entries are reset so the head fields read 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
        err_q[i]  <= 1'b0;
      end
    end else if (enq) begin
      data_q[wr_ptr_q] <= alu_res;
      rd_q[wr_ptr_q]   <= alu_rd;
      err_q[wr_ptr_q]  <= alu_error;
    end
  end

endmodule

// File: tb/tb_alu_commit_queue.sv
// tb_alu_commit_queue
// Purpose: directed plus randomized stimulus for alu_commit_queue, compared
//   every cycle against a queue-based reference model of the buffer.
// Ports: none (top-level bench).
module tb_alu_commit_queue;
  localparam int XLEN  = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] alu_res = '0;
  logic [RW-1:0]   alu_rd = '0;
  logic            alu_valid = 1'b0;
  logic            alu_error = 1'b0;
  logic            alu_req = 1'b0;
  logic            alu_clear;
  logic            flush = 1'b0;
  logic            wb_valid;
  logic            wb_ready = 1'b0;
  logic [XLEN-1:0] wb_data;
  logic [RW-1:0]   wb_rd;
  logic            wb_error;
  logic [$clog2(DEPTH):0] count;
  logic            full;
  logic            empty;

  alu_commit_queue #(.XLEN(XLEN), .REG_ADDR_W(RW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_res(alu_res), .alu_rd(alu_rd), .alu_valid(alu_valid),
    .alu_error(alu_error), .alu_req(alu_req), .alu_clear(alu_clear),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_error(wb_error),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] d;
    logic [RW-1:0]   rd;
    logic            e;
  } ent_t;

  ent_t mq[$];        // reference contents, head at index 0
  bit   m_clear = 0;  // reference alu_clear for the current cycle
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model predicts from the inputs held this cycle, then the DUT
  // outputs are compared 1 time unit after the edge.
  task automatic step();
    bit   m_full, push, pop, drop;
    ent_t e;
    m_full = (mq.size() == DEPTH);
    push   = alu_req && alu_valid && !m_full && !m_clear && !flush;
    pop    = (mq.size() != 0) && wb_ready && !flush;
    e      = {alu_res, alu_rd, alu_error};
`ifdef ALU_COMMIT_X0_DROP_EN
    drop   = (alu_rd == 0) && !alu_error;
`else
    drop   = 1'b0;
`endif
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
      m_clear = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push && !drop) mq.push_back(e);
      m_clear = push;
    end
    #1;
    chk("count", 64'(count), 64'(mq.size()));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("wb_valid", 64'(wb_valid), 64'(mq.size() != 0));
    chk("alu_clear", 64'(alu_clear), 64'(m_clear));
    if (mq.size() != 0) begin
      chk("wb_data", 64'(wb_data), 64'(mq[0].d));
      chk("wb_rd", 64'(wb_rd), 64'(mq[0].rd));
      chk("wb_error", 64'(wb_error), 64'(mq[0].e));
    end
  endtask

  // ALU side: present a result, wait for the clear pulse, hold req through
  // the clear cycle as a real ALU would, then drop it.
  task automatic alu_issue(input logic [XLEN-1:0] d, input logic [RW-1:0] r, input bit er);
    int n = 0;
    alu_req = 1'b1; alu_valid = 1'b1; alu_res = d; alu_rd = r; alu_error = er;
    do begin
      step();
      n++;
    end while (!alu_clear && n < 30);
    chk("issue_clear_seen", 64'(alu_clear), 64'(1));
    step();
    alu_req = 1'b0; alu_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst_wb_data", 64'(wb_data), 64'(0));
    chk("rst_wb_rd", 64'(wb_rd), 64'(0));
    chk("rst_wb_error", 64'(wb_error), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_clear", 64'(alu_clear), 64'(0));
    rst = 1'b0;
    step();

    // Single result straight through
    wb_ready = 1'b1;
    alu_req = 1'b1; alu_valid = 1'b1; alu_res = 32'h0000_1234; alu_rd = 5'd7; alu_error = 1'b0;
    step();
    chk("single_clear", 64'(alu_clear), 64'(1));
    chk("single_valid", 64'(wb_valid), 64'(1));
    chk("single_data", 64'(wb_data), 64'h1234);
    chk("single_rd", 64'(wb_rd), 64'(7));
    step();
    chk("single_clear_width", 64'(alu_clear), 64'(0));
    chk("single_empty", 64'(empty), 64'(1));
    alu_req = 1'b0; alu_valid = 1'b0;
    step();

    // Fill to DEPTH, fifth request must be held off
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) alu_issue(32'h100 + i, RW'(i), 1'b0);
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_count", 64'(count), 64'(4));
    alu_req = 1'b1; alu_valid = 1'b1; alu_res = 32'h105; alu_rd = 5'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fill_held_no_clear", 64'(alu_clear), 64'(0));
    end
    wb_ready = 1'b1;
    chk("fill_head1", 64'(wb_rd), 64'(1));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fill_order", 64'(wb_rd), 64'(k + 2));
      if (k == 1) chk("fill_fifth_clear", 64'(alu_clear), 64'(1));
      if (k == 2) begin alu_req = 1'b0; alu_valid = 1'b0; end
    end
    step();
    chk("fill_drained", 64'(empty), 64'(1));

    // Simultaneous push/pop at count 2, across several pointer wraps
    wb_ready = 1'b0;
    alu_issue(32'hA0, 5'd20, 1'b0);
    alu_issue(32'hA1, 5'd21, 1'b0);
    for (int i = 0; i < 9; i++) begin
      wb_ready = 1'b1;
      alu_req = 1'b1; alu_valid = 1'b1; alu_res = 32'hB0 + i; alu_rd = RW'(i + 8);
      step();
      chk("pp_count", 64'(count), 64'(2));
      wb_ready = 1'b0;
      step();
      alu_req = 1'b0; alu_valid = 1'b0;
    end
    wb_ready = 1'b1;
    step(); step(); step();

    // Flush with a push in the previous cycle
    wb_ready = 1'b0;
    alu_issue(32'hC0, 5'd1, 1'b0);
    alu_issue(32'hC1, 5'd2, 1'b0);
    alu_req = 1'b1; alu_valid = 1'b1; alu_res = 32'hC2; alu_rd = 5'd3;
    step();
    chk("flush_pre_count", 64'(count), 64'(3));
    chk("flush_pending_clear", 64'(alu_clear), 64'(1));
    flush = 1'b1;
    step();
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_valid", 64'(wb_valid), 64'(0));
    chk("flush_clear_once", 64'(alu_clear), 64'(0));
    flush = 1'b0; alu_req = 1'b0; alu_valid = 1'b0;
    step();

    // Error propagation
    alu_issue(32'hFFFF_FFFF, 5'd5, 1'b1);
    chk("err_flag", 64'(wb_error), 64'(1));
    chk("err_data", 64'(wb_data), 64'hFFFF_FFFF);
    chk("err_rd", 64'(wb_rd), 64'(5));
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // Destination x0
    alu_issue(32'h0000_ABCD, 5'd0, 1'b0);
`ifdef ALU_COMMIT_X0_DROP_EN
    chk("x0_dropped", 64'(count), 64'(0));
`else
    chk("x0_kept", 64'(count), 64'(1));
    chk("x0_rd", 64'(wb_rd), 64'(0));
`endif
    wb_ready = 1'b1;
    step(); step();

    // Randomized traffic, including rare flush and mid-run reset
    for (int c = 0; c < 2500; c++) begin
      rst      = ($urandom_range(199) == 0);
      flush    = ($urandom_range(49) == 0);
      wb_ready = ($urandom_range(2) != 0);
      if (alu_clear || !alu_req) begin
        alu_req   = $urandom_range(1);
        alu_res   = $urandom;
        alu_rd    = RW'($urandom_range(31));
        alu_error = ($urandom_range(7) == 0);
      end
      alu_valid = ($urandom_range(7) != 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; alu_req = 1'b0; alu_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
